// File: rtl/uart_deser.sv
// Serial-to-parallel word assembler driven by an external bit strobe.
// Optional trailing parity bit, single-entry output register with overrun flag.
module uart_deser #(
  parameter int DATA_W     = 8,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              shift,
  input  logic              clear,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int N  = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CW = $clog2(N);

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_ins;
  logic              last;
  logic              complete;
  logic              perr_calc;

  // Word as it would look with the current bit inserted; the parity slot
  // (count == DATA_W) matches no data position and leaves the word untouched.
  always_comb begin
    sh_ins = sh;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(count) == ((LSB_FIRST != 0) ? i : DATA_W - 1 - i)) begin
        sh_ins[i] = data_in;
      end
    end
  end

  always_comb begin
    perr_calc = 1'b0;
    if (PARITY_EN != 0) begin
      perr_calc = (^sh_ins) ^ data_in ^ (PARITY_ODD != 0);
    end
  end

  assign last     = (count == CW'(N - 1));
  assign complete = shift && !clear && last;

  // Output handshake: a word is transferred on any edge where out_valid and
  // out_ready are both high; a completion may refill the register on that
  // same edge, otherwise a completion while out_valid is held is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      sh         <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clear) begin
        count   <= '0;
        sh      <= '0;
        busy    <= 1'b0;
        overrun <= 1'b0;
      end else if (shift) begin
        if (last) begin
          count <= '0;
          sh    <= '0;
          busy  <= 1'b0;
        end else begin
          count <= count + CW'(1);
          sh    <= sh_ins;
          busy  <= 1'b1;
        end
      end

      if (complete) begin
        if (!out_valid || out_ready) begin
          data_out   <= sh_ins;
          parity_err <= perr_calc;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_deser.sv
// Directed bench for uart_deser: three instances (LSB-first, MSB-first,
// even parity) share serial inputs; per-instance shift strobes select targets.
module tb_uart_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data_in = 1'b0;
  logic shift = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic [2:0] sel = 3'b000;

  logic       shift_l, shift_m, shift_p;
  logic [7:0] l_data, m_data, p_data;
  logic       l_valid, l_perr, l_ovr, l_busy;
  logic       m_valid, m_perr, m_ovr, m_busy;
  logic       p_valid, p_perr, p_ovr, p_busy;

  int n_cmp = 0;
  int n_bad = 0;

  assign shift_l = shift & sel[0];
  assign shift_m = shift & sel[1];
  assign shift_p = shift & sel[2];

  always #5 clk = ~clk;

  uart_deser #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .shift(shift_l), .clear(clear),
    .out_ready(out_ready), .data_out(l_data), .out_valid(l_valid),
    .parity_err(l_perr), .overrun(l_ovr), .busy(l_busy)
  );

  uart_deser #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .shift(shift_m), .clear(clear),
    .out_ready(out_ready), .data_out(m_data), .out_valid(m_valid),
    .parity_err(m_perr), .overrun(m_ovr), .busy(m_busy)
  );

  uart_deser #(.DATA_W(8), .LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .data_in(data_in), .shift(shift_p), .clear(clear),
    .out_ready(out_ready), .data_out(p_data), .out_valid(p_valid),
    .parity_err(p_perr), .overrun(p_ovr), .busy(p_busy)
  );

  // v[0] is shifted first; returns at the negedge after the last capture edge.
  task automatic send_bits(input logic [9:0] v, input int n, input int gap,
                           input logic ready_on_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = v[i];
      shift   = 1'b1;
      if (i == n - 1) out_ready = ready_on_last;
      @(negedge clk);
      shift     = 1'b0;
      out_ready = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (l_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", l_data); end
    n_cmp++; if ({l_valid, l_perr, l_ovr, l_busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags_lsb got %b want 0000", {l_valid, l_perr, l_ovr, l_busy}); end
    n_cmp++; if ({p_valid, p_perr, p_ovr, p_busy, m_valid, m_busy} !== 6'b0) begin n_bad++; $display("FAIL reset_flags_other got %b want 000000", {p_valid, p_perr, p_ovr, p_busy, m_valid, m_busy}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 3'b011;
    send_bits(10'h04D, 7, 0, 1'b0);
    n_cmp++; if ({l_valid, l_busy} !== 2'b01) begin n_bad++; $display("FAIL basic_seven_bits valid,busy got %b want 01", {l_valid, l_busy}); end
    send_bits(10'h04D >> 7, 1, 0, 1'b0);
    n_cmp++; if (l_data !== 8'h4D) begin n_bad++; $display("FAIL basic_lsb_data got %h want 4d", l_data); end
    n_cmp++; if ({l_valid, l_busy, l_perr} !== 3'b100) begin n_bad++; $display("FAIL basic_lsb_flags got %b want 100", {l_valid, l_busy, l_perr}); end
    n_cmp++; if (m_data !== 8'hB2) begin n_bad++; $display("FAIL basic_msb_data got %h want b2", m_data); end
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL basic_msb_valid got %b want 1", m_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({l_valid, l_data} !== {1'b1, 8'h4D}) begin n_bad++; $display("FAIL basic_hold got %b/%h want 1/4d", l_valid, l_data); end
    accept();
    n_cmp++; if ({l_valid, m_valid} !== 2'b00) begin n_bad++; $display("FAIL basic_accept valids got %b want 00", {l_valid, m_valid}); end
    n_cmp++; if (l_data !== 8'h4D) begin n_bad++; $display("FAIL basic_data_after_accept got %h want 4d", l_data); end
  endtask

  task automatic test_idle_gaps();
    sel = 3'b010;
    send_bits(10'h04D, 8, 2, 1'b0);
    n_cmp++; if ({m_valid, m_data} !== {1'b1, 8'hB2}) begin n_bad++; $display("FAIL gaps_msb got %b/%h want 1/b2", m_valid, m_data); end
    n_cmp++; if (l_valid !== 1'b0) begin n_bad++; $display("FAIL gaps_unselected_valid got %b want 0", l_valid); end
    accept();
  endtask

  task automatic test_parity();
    sel = 3'b100;
    send_bits(10'h04D, 8, 0, 1'b0);
    n_cmp++; if ({p_valid, p_busy} !== 2'b01) begin n_bad++; $display("FAIL parity_eight_bits valid,busy got %b want 01", {p_valid, p_busy}); end
    send_bits(10'h000, 1, 0, 1'b0);
    n_cmp++; if ({p_valid, p_perr, p_data} !== {2'b10, 8'h4D}) begin n_bad++; $display("FAIL parity_good got %b/%b/%h want 1/0/4d", p_valid, p_perr, p_data); end
    accept();
    send_bits(10'h14D, 9, 0, 1'b0);
    n_cmp++; if ({p_valid, p_perr, p_data} !== {2'b11, 8'h4D}) begin n_bad++; $display("FAIL parity_bad got %b/%b/%h want 1/1/4d", p_valid, p_perr, p_data); end
    n_cmp++; if (p_busy !== 1'b0) begin n_bad++; $display("FAIL parity_busy got %b want 0", p_busy); end
    accept();
  endtask

  task automatic test_overrun();
    sel = 3'b001;
    send_bits(10'h04D, 8, 0, 1'b0);
    send_bits(10'h011, 8, 0, 1'b0);
    n_cmp++; if ({l_valid, l_data} !== {1'b1, 8'h4D}) begin n_bad++; $display("FAIL ovr_keep_old got %b/%h want 1/4d", l_valid, l_data); end
    n_cmp++; if (l_ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", l_ovr); end
    accept();
    n_cmp++; if ({l_valid, l_ovr} !== 2'b01) begin n_bad++; $display("FAIL ovr_after_accept valid,ovr got %b want 01", {l_valid, l_ovr}); end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++; if ({l_ovr, l_data} !== {1'b0, 8'h4D}) begin n_bad++; $display("FAIL ovr_clear got %b/%h want 0/4d", l_ovr, l_data); end
  endtask

  task automatic test_back_to_back();
    sel = 3'b001;
    send_bits(10'h04D, 8, 0, 1'b0);
    send_bits(10'h011, 8, 0, 1'b1);
    n_cmp++; if ({l_valid, l_data} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL b2b_data got %b/%h want 1/11", l_valid, l_data); end
    n_cmp++; if (l_ovr !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", l_ovr); end
  endtask

  task automatic test_abort();
    sel = 3'b001;
    send_bits(10'h3FF, 3, 0, 1'b0);
    n_cmp++; if (l_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", l_busy); end
    @(negedge clk); clear = 1'b1; shift = 1'b1; data_in = 1'b1;
    @(negedge clk); clear = 1'b0; shift = 1'b0;
    n_cmp++; if (l_busy !== 1'b0) begin n_bad++; $display("FAIL abort_clear_busy got %b want 0", l_busy); end
    n_cmp++; if ({l_valid, l_data} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL abort_clear_keeps_out got %b/%h want 1/11", l_valid, l_data); end
    accept();
    send_bits(10'h04D, 8, 0, 1'b0);
    n_cmp++; if ({l_valid, l_data} !== {1'b1, 8'h4D}) begin n_bad++; $display("FAIL abort_clean_word got %b/%h want 1/4d", l_valid, l_data); end
    accept();
    send_bits(10'h3FF, 3, 0, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    n_cmp++; if ({l_busy, l_valid, l_data} !== {2'b00, 8'h00}) begin n_bad++; $display("FAIL abort_reset got %b/%b/%h want 0/0/00", l_busy, l_valid, l_data); end
    send_bits(10'h011, 8, 1, 1'b0);
    n_cmp++; if ({l_valid, l_data, l_busy} !== {1'b1, 8'h11, 1'b0}) begin n_bad++; $display("FAIL abort_after_reset got %b/%h/%b want 1/11/0", l_valid, l_data, l_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_gaps();
    test_parity();
    test_overrun();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_deser.md
UART_DESER -- requirements
Module: uart_deser

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per word, legal range 5..9.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning first received bit is word bit 0 (0 = first bit is bit DATA_W-1).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning one parity bit follows the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; ignored when PARITY_EN=0.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port data_in, input, 1, serial bit, sampled only when shift=1.
REQ-008 The block SHALL have port shift, input, 1, one-cycle strobe: capture data_in this edge.
REQ-009 The block SHALL have port clear, input, 1, synchronous abort of partial frame plus clear of overrun.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts data_out.
REQ-011 The block SHALL have port data_out, output, DATA_W, last completed word, registered.
REQ-012 The block SHALL have port out_valid, output, 1, data_out holds an unconsumed word.
REQ-013 The block SHALL have port parity_err, output, 1, parity failure for data_out, qualified by out_valid; constant 0 when PARITY_EN=0.
REQ-014 The block SHALL have port overrun, output, 1, sticky: a completed word was dropped.
REQ-015 The block SHALL have port busy, output, 1, high while bit count is nonzero (partial frame held).

Function
REQ-016 Frame length N SHALL equal DATA_W+PARITY_EN bits; a bit counter SHALL count 0..N-1 and advance only on edges where shift=1.
REQ-017 LSB_FIRST=1 SHALL place the k-th received data bit (k from 0) in word bit k; LSB_FIRST=0 SHALL place it in word bit DATA_W-1-k.
REQ-018 With PARITY_EN=1, the parity bit SHALL be the N-th (last) received bit and SHALL NOT appear in data_out.
REQ-019 On the edge where shift=1 and count=N-1, the block SHALL form the complete word including that bit, return count to 0, and perform the completion action (REQ-020..022) on the same edge; out_valid SHALL be visible the cycle after that edge.
REQ-020 On completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, the block SHALL load data_out and parity_err and hold out_valid=1.
REQ-021 On completion with out_valid=1 and out_ready=0, the block SHALL keep the old data_out and parity_err, drop the new word, and set overrun=1.
REQ-022 Parity check SHALL flag parity_err=1 when XOR of data bits and parity bit is 1 (even) or 0 (odd).
REQ-023 out_valid SHALL clear on an edge where out_valid=1 and out_ready=1 and no completion occurs; out_ready while out_valid=0 SHALL have no effect.
REQ-024 out_valid SHALL hold data_out and parity_err stable until accepted.
REQ-025 clear=1 SHALL zero the count and partial shift contents and clear overrun; it SHALL take priority over a same-cycle shift (bit discarded, no completion); it SHALL NOT affect data_out, out_valid or parity_err.
REQ-026 overrun SHALL remain 1 until clear or reset; overrun SHALL NOT block later completions.
REQ-027 busy SHALL equal (count != 0), registered with the count.

Reset
REQ-028 rst=0 SHALL asynchronously force count=0, shift contents=0, data_out=0, out_valid=0, parity_err=0, overrun=0, busy=0, aborting any partial frame.
REQ-029 After rst deasserts, the first shift=1 edge SHALL be treated as bit 0 of a new frame.

Verification
REQ-030 DATA_W=8, LSB_FIRST=1, PARITY_EN=0: shift bits 1,0,1,1,0,0,1,0 -> data_out=0x4D, out_valid=1 the cycle after the 8th shift, busy=0.
REQ-031 Same bits with LSB_FIRST=0 -> data_out=0xB2; idle cycles (shift=0) between bits -> identical result.
REQ-032 PARITY_EN=1, PARITY_ODD=0: bits of 0x4D then parity 0 -> parity_err=0; repeat with parity 1 -> parity_err=1.
REQ-033 Word 0x4D pending with out_ready=0, second frame 0x11 completes -> data_out stays 0x4D, overrun=1; out_ready=1 -> out_valid=0; clear -> overrun=0.
REQ-034 Pending word accepted on the same edge a new frame 0x11 completes -> data_out=0x11, out_valid stays 1, overrun=0.
REQ-035 Reset or clear after 3 shifted bits -> busy=0; next 8 shifts yield a clean word with no leftover bits.
